// File: rtl/key_expander.sv
// Iterative AES-128/AES-256 key expander: streams round keys 0..Nr with a valid/ready handshake.
// Optional build macro KEY_EXPANDER_ZEROIZE_EN clears the key window after the final key is consumed.
module key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        round_key,
  output logic [3:0]          rk_index,
  output logic                done
);

  localparam int         NK = KEY_BITS / 32;
  localparam logic [3:0] NR = 4'(NK + 6);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_expander: KEY_BITS must be 128 or 256");
  end

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [KEY_BITS-1:0] window;
  logic [7:0]          rcon;

  logic                rot_step;
  logic [31:0]         w_last;
  logic [31:0]         temp;
  logic [31:0]         n0, n1, n2, n3;
  logic [127:0]        new_words;
  logic [KEY_BITS-1:0] next_window;

  assign round_key = window[KEY_BITS-1 -: 128];

  // For Nk=8 the RotWord/Rcon step applies on even rounds (i mod 8 == 0), SubWord only on odd ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rot_step  = (NK == 4) ? 1'b1 : ~rk_index[0];
    w_last    = window[31:0];
    temp      = rot_step ? (sub_word({w_last[23:0], w_last[31:24]}) ^ {rcon, 24'h0})
                         : sub_word(w_last);
    n0        = window[KEY_BITS-1  -: 32] ^ temp;
    n1        = window[KEY_BITS-33 -: 32] ^ n0;
    n2        = window[KEY_BITS-65 -: 32] ^ n1;
    n3        = window[KEY_BITS-97 -: 32] ^ n2;
    new_words = {n0, n1, n2, n3};
  end

  if (NK == 8) begin : g_nk8
    assign next_window = {window[127:0], new_words};
  end else begin : g_nk4
    assign next_window = new_words;
  end

  // NOTE: the key window is cleared by the asynchronous reset so an aborted run leaves no key material.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      window   <= '0;
      rcon     <= 8'h01;
      rk_index <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            window   <= key_in;
            rk_index <= 4'd0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (rk_index == NR) begin
              state    <= IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef KEY_EXPANDER_ZEROIZE_EN
              window   <= '0;
`else
              window   <= window;
`endif
            end else begin
              window   <= next_window;
              rk_index <= rk_index + 4'd1;
              if (rot_step) rcon <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Randomized bench for key_expander: AES-128 and AES-256 instances checked against a FIPS-197 style
// key-schedule model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         rk_ready;
  logic         sel256;
  logic [255:0] key;

  logic         busy_a, valid_a, done_a;
  logic [127:0] rk_a;
  logic [3:0]   idx_a;
  logic         busy_b, valid_b, done_b;
  logic [127:0] rk_b;
  logic [3:0]   idx_b;

  logic         busy_o, valid_o, done_o;
  logic [127:0] rk_o;
  logic [3:0]   idx_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [15];
  logic [127:0] got_rk   [15];
  int           nvalid;

  key_expander #(.KEY_BITS(128)) dut128 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & ~sel256),
    .key_in    (key[127:0]),
    .busy      (busy_a),
    .rk_valid  (valid_a),
    .rk_ready  (rk_ready & ~sel256),
    .round_key (rk_a),
    .rk_index  (idx_a),
    .done      (done_a)
  );

  key_expander #(.KEY_BITS(256)) dut256 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & sel256),
    .key_in    (key),
    .busy      (busy_b),
    .rk_valid  (valid_b),
    .rk_ready  (rk_ready & sel256),
    .round_key (rk_b),
    .rk_index  (idx_b),
    .done      (done_b)
  );

  assign busy_o  = sel256 ? busy_b  : busy_a;
  assign valid_o = sel256 ? valid_b : valid_a;
  assign done_o  = sel256 ? done_b  : done_a;
  assign rk_o    = sel256 ? rk_b    : rk_a;
  assign idx_o   = sel256 ? idx_b   : idx_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook key schedule over a flat word array.
  task automatic build_model(input logic [255:0] k, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = k[32*(nk-1-j) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_keys(input logic [255:0] k, input bit is256, input int duty,
                          input int inject_at, input int reset_at, input bit final_start);
    int           nk, nr, r, cycles;
    bit           hs, prev_hs, aborted;
    logic [127:0] prev;
    sel256  = is256;
    nk      = is256 ? 8 : 4;
    nr      = nk + 6;
    build_model(k, nk);
    key     = is256 ? k : {128'h0, k[127:0]};
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    check("busy_after_start", 128'(busy_o), 128'd1);
    r       = 0;
    cycles  = 0;
    nvalid  = 0;
    aborted = 1'b0;
    prev_hs = 1'b1;
    prev    = '0;
    while (r <= nr && cycles < 400) begin
      cycles++;
      check("valid", 128'(valid_o), 128'd1);
      check("busy", 128'(busy_o), 128'd1);
      check("done_low", 128'(done_o), 128'd0);
      check("index", 128'(idx_o), 128'(r));
      check("round_key", rk_o, exp_rk[r]);
      if (!prev_hs) check("hold_key", rk_o, prev);
      if (valid_o) nvalid++;
      if (r == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_valid", 128'(valid_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        check("rst_index", 128'(idx_o), 128'd0);
        check("rst_key", rk_o, 128'd0);
        rk_ready = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      rk_ready = ($urandom_range(0, 99) < duty);
      if (r == inject_at) begin
        start = 1'b1;
        key   = '1;
      end
      if (r == nr && final_start) start = 1'b1;
      hs   = rk_ready;
      prev = rk_o;
      @(posedge clk); #1;
      start   = 1'b0;
      prev_hs = hs;
      if (hs) begin
        got_rk[r] = prev;
        r++;
      end
    end
    rk_ready = 1'b0;
    if (!aborted) begin
      if (r <= nr) begin
        check("timeout", 128'(r), 128'(nr + 1));
      end else begin
        check("done_pulse", 128'(done_o), 128'd1);
        check("valid_drop", 128'(valid_o), 128'd0);
        check("busy_drop", 128'(busy_o), 128'd0);
`ifdef KEY_EXPANDER_ZEROIZE_EN
        check("idle_key", rk_o, 128'd0);
`else
        check("idle_key", rk_o, exp_rk[nr]);
`endif
        if (duty >= 100) check("valid_cycles", 128'(nvalid), 128'(nr + 1));
        @(posedge clk); #1;
        check("done_once", 128'(done_o), 128'd0);
        check("stay_idle", 128'(valid_o), 128'd0);
      end
    end
  endtask

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    sel256   = 1'b0;
    key      = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_a", 128'(busy_a), 128'd0);
    check("reset_valid_a", 128'(valid_a), 128'd0);
    check("reset_done_a", 128'(done_a), 128'd0);
    check("reset_index_a", 128'(idx_a), 128'd0);
    check("reset_key_a", rk_a, 128'd0);
    check("reset_valid_b", 128'(valid_b), 128'd0);
    check("reset_key_b", rk_b, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_keys({128'h0, KEY_A}, 1'b0, 100, -1, -1, 1'b0);
    check("fips_a_rk0", got_rk[0], KEY_A);
    check("fips_a_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_a_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_keys(KEY_C, 1'b1, 100, -1, -1, 1'b0);
    check("fips_c_rk1", got_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("fips_c_rk2", got_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check("fips_c_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    run_keys({128'h0, KEY_A}, 1'b0, 30, -1, -1, 1'b0);
    check("bp_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_keys({128'h0, KEY_A}, 1'b0, 100, 3, -1, 1'b1);
    check("busy_start_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_keys({128'h0, KEY_A}, 1'b0, 100, -1, 5, 1'b0);
    run_keys({128'h0, 128'h00112233445566778899aabbccddeeff}, 1'b0, 100, -1, -1, 1'b0);
    check("post_reset_rk0", got_rk[0], 128'h00112233445566778899aabbccddeeff);

    for (int n = 0; n < 6; n++) begin
      logic [255:0] rk;
      for (int q = 0; q < 8; q++) rk[32*q +: 32] = $urandom;
      run_keys(rk, n[0], $urandom_range(20, 100), -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
